// File: rtl/sig_slicer.sv
// sig_slicer: moving-average smoother and hysteresis slicer for signed amplitude samples.
//
// Samples are averaged over a 2^LOG2_AVG window. Each averaged sample steps a four-state
// hysteresis FSM with a glitch filter, which commits the binary line level only after
// min_run consecutive qualifying averages. Every committed change reports the run length
// of the level being left.
//
// Ports:
//   clk, reset_l        clock, asynchronous active-low reset
//   sample_i            signed W-bit amplitude sample
//   sample_valid        qualifier for sample_i (may be high every cycle)
//   wr_en/addr/data     config writes: 0 thr_hi, 1 thr_lo, 2 min_run, 3 ctrl
//                       (ctrl bit0 enable, bit1 write-1 clear pulse)
//   avg_o               registered signed moving average
//   level_o             sliced line level
//   level_valid         pulse: avg_o / level_o refreshed (two cycles after the sample)
//   edge_o              pulse on a committed level change (only with level_valid)
//   run_len_o           averaged samples spent in the previous level, valid with edge_o
module sig_slicer #(
  parameter int unsigned W        = 32,
  parameter int unsigned LOG2_AVG = 3,
  parameter int unsigned RUN_W    = 16
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic signed [W-1:0] sample_i,
  input  logic                sample_valid,
  input  logic                wr_en,
  input  logic [1:0]          wr_addr,
  input  logic [31:0]         wr_data,
  output logic signed [W-1:0] avg_o,
  output logic                level_o,
  output logic                level_valid,
  output logic                edge_o,
  output logic [RUN_W-1:0]    run_len_o
);

  localparam int unsigned Depth = 1 << LOG2_AVG;
  localparam int unsigned AccW  = W + LOG2_AVG;
  localparam int unsigned CmpW  = (W > 32) ? W : 32;
  localparam int unsigned FillW = LOG2_AVG + 1;

  localparam logic [1:0] StLow    = 2'd0;
  localparam logic [1:0] StPendHi = 2'd1;
  localparam logic [1:0] StHigh   = 2'd2;
  localparam logic [1:0] StPendLo = 2'd3;

  // Config registers
  logic signed [31:0] thr_hi_q, thr_lo_q;
  logic [7:0]         min_run_q;
  logic               enable_q;
  logic               clr;

  assign clr = wr_en && (wr_addr == 2'd3) && wr_data[1];

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      thr_hi_q  <= 32'sd1000;
      thr_lo_q  <= 32'sd500;
      min_run_q <= 8'd4;
      enable_q  <= 1'b1;
    end else if (wr_en) begin
      unique case (wr_addr)
        2'd0: thr_hi_q  <= $signed(wr_data);
        2'd1: thr_lo_q  <= $signed(wr_data);
        2'd2: min_run_q <= wr_data[7:0];
        2'd3: enable_q  <= wr_data[0];
      endcase
    end
  end

  // Stage 1: window buffer, accumulator, fill count
  logic signed [W-1:0]    win_q [Depth];
  logic [LOG2_AVG-1:0]    wptr_q;
  logic [FillW-1:0]       fill_q;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [W-1:0]    avg_s1_d;
  logic                   accept;
  logic                   s1_valid_d;

  // Stage 1 -> 2 pipeline; thresholds are resolved here so a config write landing
  // with a sample cannot affect that sample's comparison.
  logic                   s1_valid_q;
  logic signed [W-1:0]    s1_avg_q;
  logic                   s1_gt_hi_q, s1_lt_lo_q;
  logic [7:0]             s1_min_run_q;

  assign accept     = sample_valid && enable_q && !clr;
  assign acc_d      = acc_q + AccW'(sample_i) - AccW'(win_q[wptr_q]);
  assign avg_s1_d   = W'(acc_d >>> LOG2_AVG);
  // This sample completes (or follows) a full window
  assign s1_valid_d = accept && (fill_q >= FillW'(Depth - 1));

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int unsigned i = 0; i < Depth; i++) win_q[i] <= '0;
      wptr_q       <= '0;
      fill_q       <= '0;
      acc_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_avg_q     <= '0;
      s1_gt_hi_q   <= 1'b0;
      s1_lt_lo_q   <= 1'b0;
      s1_min_run_q <= 8'd1;
    end else if (clr) begin
      for (int unsigned i = 0; i < Depth; i++) win_q[i] <= '0;
      wptr_q     <= '0;
      fill_q     <= '0;
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_avg_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        win_q[wptr_q] <= sample_i;
        acc_q         <= acc_d;
        wptr_q        <= wptr_q + LOG2_AVG'(1);
        if (fill_q != FillW'(Depth)) fill_q <= fill_q + FillW'(1);
        s1_avg_q      <= avg_s1_d;
        s1_gt_hi_q    <= CmpW'(avg_s1_d) > CmpW'(thr_hi_q);
        s1_lt_lo_q    <= CmpW'(avg_s1_d) < CmpW'(thr_lo_q);
        s1_min_run_q  <= (min_run_q == 8'd0) ? 8'd1 : min_run_q;
      end
    end
  end

  // Stage 2: registered average and slicer FSM
  logic [1:0]          state_q, state_d, tgt;
  logic [7:0]          pend_q, pend_d, pend_inc;
  logic [RUN_W-1:0]    run_q, run_d, run_inc;
  logic [RUN_W-1:0]    run_len_q, run_len_d;
  logic signed [W-1:0] avg_q, avg_d;
  logic                level_q, level_d;
  logic                lv_q;
  logic                edge_q, edge_d;
  logic                commit;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    run_d     = run_q;
    run_len_d = run_len_q;
    avg_d     = avg_q;
    level_d   = level_q;
    edge_d    = 1'b0;
    commit    = 1'b0;
    tgt       = StLow;
    run_inc   = (run_q == {RUN_W{1'b1}}) ? run_q : run_q + RUN_W'(1);
    // pend is 0 in the settled states, so pend_inc is also the first pending count
    pend_inc  = pend_q + 8'd1;
    if (s1_valid_q) begin
      avg_d = s1_avg_q;
      run_d = run_inc;
      unique case (state_q)
        StLow, StPendHi: begin
          if (s1_gt_hi_q) begin
            if (pend_inc >= s1_min_run_q) begin
              commit = 1'b1;
              tgt    = StHigh;
            end else begin
              state_d = StPendHi;
              pend_d  = pend_inc;
            end
          end else begin
            state_d = StLow;
            pend_d  = '0;
          end
        end
        StHigh, StPendLo: begin
          if (s1_lt_lo_q) begin
            if (pend_inc >= s1_min_run_q) begin
              commit = 1'b1;
              tgt    = StLow;
            end else begin
              state_d = StPendLo;
              pend_d  = pend_inc;
            end
          end else begin
            state_d = StHigh;
            pend_d  = '0;
          end
        end
      endcase
      if (commit) begin
        state_d   = tgt;
        pend_d    = '0;
        level_d   = (tgt == StHigh);
        edge_d    = 1'b1;
        // The pending samples already belong to the new level
        run_len_d = run_inc - RUN_W'(s1_min_run_q);
        run_d     = RUN_W'(s1_min_run_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= StLow;
      pend_q    <= '0;
      run_q     <= '0;
      run_len_q <= '0;
      avg_q     <= '0;
      level_q   <= 1'b0;
      lv_q      <= 1'b0;
      edge_q    <= 1'b0;
    end else if (clr) begin
      state_q   <= StLow;
      pend_q    <= '0;
      run_q     <= '0;
      run_len_q <= '0;
      avg_q     <= '0;
      level_q   <= 1'b0;
      lv_q      <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      run_q     <= run_d;
      run_len_q <= run_len_d;
      avg_q     <= avg_d;
      level_q   <= level_d;
      lv_q      <= s1_valid_q;
      edge_q    <= edge_d;
    end
  end

  assign avg_o       = avg_q;
  assign level_o     = level_q;
  assign level_valid = lv_q;
  assign edge_o      = edge_q;
  assign run_len_o   = run_len_q;

endmodule

// File: tb/tb_sig_slicer.sv
module tb_sig_slicer;

  logic               clk = 1'b0;
  logic               reset_l;
  logic signed [31:0] sample_i;
  logic               sample_valid;
  logic               wr_en;
  logic [1:0]         wr_addr;
  logic [31:0]        wr_data;
  logic signed [31:0] avg_o;
  logic               level_o;
  logic               level_valid;
  logic               edge_o;
  logic [15:0]        run_len_o;

  int checks   = 0;
  int failures = 0;

  sig_slicer #(.W(32), .LOG2_AVG(3), .RUN_W(16)) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .sample_i     (sample_i),
    .sample_valid (sample_valid),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .avg_o        (avg_o),
    .level_o      (level_o),
    .level_valid  (level_valid),
    .edge_o       (edge_o),
    .run_len_o    (run_len_o)
  );

  always #5 clk = ~clk;

  // One isolated sample; returns on the negedge where its level_valid would be visible.
  task automatic step(input logic signed [31:0] s);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_i     = s;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (avg_o !== 32'sd0 || level_o !== 1'b0 || level_valid !== 1'b0 || edge_o !== 1'b0 ||
        run_len_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs got avg=%0d lvl=%0b lv=%0b edge=%0b run=%0d exp all 0",
               avg_o, level_o, level_valid, edge_o, run_len_o);
    end
  endtask

  task automatic test_fill_latency;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (level_valid !== 1'b0) begin
        failures++;
        $display("FAIL fill_no_lv[%0d] got=%0b exp=0", i, level_valid);
      end
      sample_valid = 1'b1;
      sample_i     = 32'sd2000;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    checks++;
    if (level_valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_lv_sample7 got=%0b exp=0", level_valid);
    end
    @(negedge clk);
    checks++;
    if (level_valid !== 1'b1 || avg_o !== 32'sd2000 || edge_o !== 1'b0) begin
      failures++;
      $display("FAIL fill_first_avg got lv=%0b avg=%0d edge=%0b exp lv=1 avg=2000 edge=0",
               level_valid, avg_o, edge_o);
    end
  endtask

  task automatic test_hysteresis;
    // Averaged samples 2..4 at 2000; commit on the 4th
    for (int i = 2; i <= 4; i++) begin
      step(32'sd2000);
      checks++;
      if (edge_o !== (i == 4) || level_o !== (i == 4)) begin
        failures++;
        $display("FAIL hyst_rise[%0d] got edge=%0b lvl=%0b exp edge=%0b lvl=%0b",
                 i, edge_o, level_o, i == 4, i == 4);
      end
    end
    checks++;
    if (run_len_o !== 16'd0) begin
      failures++;
      $display("FAIL hyst_rise_runlen got=%0d exp=0", run_len_o);
    end
    step(32'sd2000);
    step(32'sd2000);
    // Window ramps down to 700; every average stays above thr_lo
    for (int k = 1; k <= 8; k++) begin
      step(32'sd700);
      checks++;
      if (level_o !== 1'b1 || edge_o !== 1'b0) begin
        failures++;
        $display("FAIL hyst_700[%0d] got lvl=%0b edge=%0b exp lvl=1 edge=0", k, level_o, edge_o);
      end
    end
    checks++;
    if (avg_o !== 32'sd700) begin
      failures++;
      $display("FAIL hyst_avg700 got=%0d exp=700", avg_o);
    end
    // Averages 662,625,587,550,512,475,437,400,400: first below 500 at k=6, commit at k=9
    for (int k = 1; k <= 8; k++) begin
      step(32'sd400);
      checks++;
      if (edge_o !== 1'b0 || level_o !== 1'b1) begin
        failures++;
        $display("FAIL hyst_fall_wait[%0d] got edge=%0b lvl=%0b exp edge=0 lvl=1",
                 k, edge_o, level_o);
      end
      if (k == 6) begin
        checks++;
        if (avg_o !== 32'sd475) begin
          failures++;
          $display("FAIL hyst_avg475 got=%0d exp=475", avg_o);
        end
      end
    end
    step(32'sd400);
    // HIGH run: 4 pending + 2 + 8 + 5 averages above thr_lo = 19
    checks++;
    if (edge_o !== 1'b1 || level_o !== 1'b0 || run_len_o !== 16'd19 || avg_o !== 32'sd400) begin
      failures++;
      $display("FAIL hyst_fall got edge=%0b lvl=%0b run=%0d avg=%0d exp edge=1 lvl=0 run=19 avg=400",
               edge_o, level_o, run_len_o, avg_o);
    end
  endtask

  task automatic test_glitch;
    wr(2'd3, 32'd3);
    for (int i = 0; i < 8; i++) step(32'sd2000);   // pend 1
    step(32'sd2000);                               // pend 2
    step(32'sd2000);                               // pend 3
    step(-32'sd6000);                              // sum 8000, avg 1000: not above thr_hi
    checks++;
    if (avg_o !== 32'sd1000 || edge_o !== 1'b0 || level_o !== 1'b0) begin
      failures++;
      $display("FAIL glitch_drop got avg=%0d edge=%0b lvl=%0b exp avg=1000 edge=0 lvl=0",
               avg_o, edge_o, level_o);
    end
    step(32'sd2008);                               // sum 8008, avg 1001: fresh pend 1
    for (int i = 2; i <= 4; i++) begin
      step(32'sd2000);
      checks++;
      if (edge_o !== (i == 4)) begin
        failures++;
        $display("FAIL glitch_pend_restart[%0d] got edge=%0b exp=%0b", i, edge_o, i == 4);
      end
    end
    // Run since clear: 8 averages, minus min_run 4
    checks++;
    if (level_o !== 1'b1 || run_len_o !== 16'd4) begin
      failures++;
      $display("FAIL glitch_commit got lvl=%0b run=%0d exp lvl=1 run=4", level_o, run_len_o);
    end
  endtask

  task automatic test_negative;
    wr(2'd3, 32'd3);
    step(-32'sd3);
    step(-32'sd3);
    for (int i = 0; i < 6; i++) step(-32'sd2);
    checks++;
    if (level_valid !== 1'b1 || avg_o !== -32'sd3 || level_o !== 1'b0) begin
      failures++;
      $display("FAIL neg_floor got lv=%0b avg=%0d lvl=%0b exp lv=1 avg=-3 lvl=0",
               level_valid, avg_o, level_o);
    end
  endtask

  task automatic test_wr_collision;
    wr(2'd2, 32'd1);
    wr(2'd3, 32'd3);
    for (int i = 0; i < 7; i++) step(32'sd100);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_i     = 32'sd100;
    wr_en        = 1'b1;
    wr_addr      = 2'd0;
    wr_data      = 32'd50;
    @(negedge clk);
    sample_valid = 1'b0;
    wr_en        = 1'b0;
    @(negedge clk);
    checks++;
    if (level_valid !== 1'b1 || avg_o !== 32'sd100 || edge_o !== 1'b0) begin
      failures++;
      $display("FAIL wr_same_cycle got lv=%0b avg=%0d edge=%0b exp lv=1 avg=100 edge=0",
               level_valid, avg_o, edge_o);
    end
    step(32'sd100);
    checks++;
    if (edge_o !== 1'b1 || level_o !== 1'b1 || run_len_o !== 16'd1) begin
      failures++;
      $display("FAIL wr_next_cycle got edge=%0b lvl=%0b run=%0d exp edge=1 lvl=1 run=1",
               edge_o, level_o, run_len_o);
    end
  endtask

  task automatic test_clear_collision;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_i     = 32'sd8000;
    wr_en        = 1'b1;
    wr_addr      = 2'd3;
    wr_data      = 32'd3;
    @(negedge clk);
    sample_valid = 1'b0;
    wr_en        = 1'b0;
    checks++;
    if (level_o !== 1'b0 || avg_o !== 32'sd0) begin
      failures++;
      $display("FAIL clear_outputs got lvl=%0b avg=%0d exp lvl=0 avg=0", level_o, avg_o);
    end
    for (int i = 1; i <= 7; i++) begin
      step(32'sd80);
      checks++;
      if (level_valid !== 1'b0) begin
        failures++;
        $display("FAIL clear_drop_fill[%0d] got lv=%0b exp=0", i, level_valid);
      end
    end
    step(32'sd80);
    checks++;
    if (level_valid !== 1'b1 || avg_o !== 32'sd80 || edge_o !== 1'b1 || run_len_o !== 16'd0) begin
      failures++;
      $display("FAIL clear_drop_avg got lv=%0b avg=%0d edge=%0b run=%0d exp lv=1 avg=80 edge=1 run=0",
               level_valid, avg_o, edge_o, run_len_o);
    end
  endtask

  task automatic test_reset_mid_run;
    wr(2'd2, 32'd4);
    wr(2'd3, 32'd3);
    for (int i = 0; i < 8; i++) step(32'sd2000);   // thr_hi is 50: PEND_HI, lv high now
    reset_l      = 1'b0;
    sample_valid = 1'b1;
    sample_i     = 32'sd2000;
    #1;
    checks++;
    if (avg_o !== 32'sd0 || level_valid !== 1'b0 || level_o !== 1'b0 || edge_o !== 1'b0 ||
        run_len_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_run got avg=%0d lv=%0b lvl=%0b edge=%0b run=%0d exp all 0",
               avg_o, level_valid, level_o, edge_o, run_len_o);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    reset_l      = 1'b1;
    // avg 600 is above the stale 50 but not the restored 1000
    for (int i = 0; i < 8; i++) step(32'sd600);
    checks++;
    if (level_valid !== 1'b1 || avg_o !== 32'sd600) begin
      failures++;
      $display("FAIL reset_refill got lv=%0b avg=%0d exp lv=1 avg=600", level_valid, avg_o);
    end
    for (int i = 0; i < 4; i++) begin
      step(32'sd600);
      checks++;
      if (edge_o !== 1'b0 || level_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_thr_restored[%0d] got edge=%0b lvl=%0b exp edge=0 lvl=0",
                 i, edge_o, level_o);
      end
    end
  endtask

  task automatic test_enable;
    wr(2'd3, 32'd0);
    step(32'sd5000);
    checks++;
    if (level_valid !== 1'b0 || avg_o !== 32'sd600) begin
      failures++;
      $display("FAIL enable_off got lv=%0b avg=%0d exp lv=0 avg=600", level_valid, avg_o);
    end
    wr(2'd3, 32'd1);
    step(32'sd600);
    checks++;
    if (level_valid !== 1'b1 || avg_o !== 32'sd600) begin
      failures++;
      $display("FAIL enable_on got lv=%0b avg=%0d exp lv=1 avg=600", level_valid, avg_o);
    end
  endtask

  initial begin
    reset_l      = 1'b0;
    sample_i     = '0;
    sample_valid = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_l = 1'b1;
    test_fill_latency();
    test_hysteresis();
    test_glitch();
    test_negative();
    test_wr_collision();
    test_clear_collision();
    test_reset_mid_run();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sig_slicer.md
# sig_slicer

Downstream stage of the floating-point arithmetic block in the demodulator chain. It consumes the signed 32-bit integer amplitude samples (`sample_i` / `sample_valid`) and smooths them with a power-of-two moving average. A hysteresis FSM with a glitch filter then slices the average into a binary line level. On every committed level change it reports the run length of the previous level, for the bit-timing recovery stage that follows.

## Interface
Parameters:
- `W`, 32: sample width (signed)
- `LOG2_AVG`, 3: log2 of moving-average window (window = 8 samples)
- `RUN_W`, 16: run-length counter width

Ports:
- `clk`  in  1  clock
- `reset_l`  in  1  reset, asynchronous, active-low
- `sample_i`  in  W  signed amplitude sample from arithmetic stage
- `sample_valid`  in  1  one-cycle qualifier for `sample_i`; may be asserted every cycle
- `wr_en`  in  1  config register write strobe
- `wr_addr`  in  2  config register address
- `wr_data`  in  32  config write data
- `avg_o`  out  W  signed moving average, registered
- `level_o`  out  1  sliced line level
- `level_valid`  out  1  one-cycle pulse; `avg_o` and `level_o` updated
- `edge_o`  out  1  one-cycle pulse on a committed level change
- `run_len_o`  out  RUN_W  averaged samples spent in the previous level; valid with `edge_o`

## Operation
Config registers (reset value in brackets):
- addr 0 `thr_hi` [1000], signed
- addr 1 `thr_lo` [500], signed
- addr 2 `min_run` [4], low 8 bits used; 0 is treated as 1
- addr 3 `ctrl`:
  - bit0 `enable` [1]
  - bit1 `clear`: write-1 self-clearing pulse, not stored

Moving average:
- Circular buffer of 2^LOG2_AVG entries; write pointer wraps modulo window size.
- Accumulator is signed, W+LOG2_AVG bits, so it cannot overflow: acc <= acc + sample_i − oldest.
- Fill counter saturates at 2^LOG2_AVG. Until the buffer is full, no `level_valid` is issued and the FSM does not step.
- avg = acc >>> LOG2_AVG (arithmetic shift, truncation toward −inf).

Slicer FSM (steps once per averaged sample); states LOW (reset), PEND_HI, HIGH, PEND_LO:
- LOW: avg > thr_hi → PEND_HI, pend=1; else stay.
- PEND_HI: avg > thr_hi → pend+1; avg ≤ thr_hi → LOW, pend=0.
  - When pend reaches `min_run`: → HIGH, `level_o`=1, `edge_o` pulse.
- HIGH / PEND_LO: mirror of the above, using avg < thr_lo.
- Comparisons are strict and signed. thr_lo > thr_hi is legal; the FSM still follows the rules above.
- Run counter counts averaged samples since the last commit and saturates at 2^RUN_W−1.
  - On commit: `run_len_o` = run − min_run; run is then reloaded with min_run (the pending samples belong to the new level).

Boundary rules:
- `enable`=0: samples are ignored; buffer, accumulator, FSM and outputs hold.
- `clear`: buffer entries, accumulator, fill, pend, run and pipeline are zeroed; FSM → LOW, `level_o`=0. Thresholds are kept.
- `clear` in the same cycle as `sample_valid`: clear wins and the sample is dropped.
- `wr_en` in the same cycle as `sample_valid`: the sample uses the old register values; the new values apply from the next cycle.
- Reset mid-operation: all state and outputs return to reset values immediately.

## Timing
- Stage 1 (edge after `sample_valid`): buffer write, accumulator update, fill update.
- Stage 2 (next edge): `avg_o` registered, FSM step; `level_valid`, `edge_o` and `run_len_o` updated.
- Latency: `sample_valid` at cycle N → `level_valid` at cycle N+2. Full throughput, one sample per cycle.
- `edge_o` is only ever high together with `level_valid`. `run_len_o` holds its value until the next edge.
- Config write takes effect on the cycle after `wr_en`. `clear` completes in one cycle.
- Output reset values: `avg_o`=0, `level_o`=0, `level_valid`=0, `edge_o`=0, `run_len_o`=0.

## Test plan
- Fill/latency: 8 samples of 2000, one every cycle → no `level_valid` for samples 1–7. Sample 8 at cycle N → `level_valid` at N+2 with `avg_o`=2000.
- Hysteresis: steady average of 2000 with `min_run`=4 → `edge_o` on the 4th averaged sample, `level_o`=1. Average of 700 → stays HIGH. Average of 400 for 4 samples → `edge_o`, `level_o`=0, and `run_len_o` equals the HIGH-run length.
- Glitch rejection: LOW state, 3 averaged samples > thr_hi then 1 ≤ thr_hi → no edge, state returns to LOW, pend cleared.
- Negative/rounding: window filled with −3, −3, −2, −2, −2, −2, −2, −2 (sum −18) → `avg_o`=−3.
- Simultaneous events:
  - `wr_en` to `thr_hi`=50 in the same cycle as a sample with average 100 → that sample is compared against 1000.
  - `clear` together with `sample_valid` → sample dropped, fill=0.
- Reset mid-run: assert `reset_l`=0 while in PEND_HI with `level_valid` in flight → all outputs 0 immediately; after release, thresholds are back to 1000/500.
